// File: rtl/sensor_reg_bank.sv
// Sensor register bank: per-channel sample registers with fresh/overrun
// flags and a byte-wide read port that snapshots multi-byte values.
module sensor_reg_bank #(
  parameter int NUM_CH = 21,
  parameter int DATA_W = 20,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  input  logic [NUM_CH-1:0]        sample_valid,
  input  logic                     freeze,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        addr,
  output logic [7:0]               data,
  output logic                     rd_valid
);

  localparam int CH_W = ADDR_W - 2;

  generate
    if (NUM_CH < 1 || NUM_CH > 64 ||
        DATA_W < 1 || DATA_W > 24 ||
        NUM_CH * 4 > 2 ** ADDR_W) begin : g_bad_cfg
      $error("sensor_reg_bank: bad NUM_CH/DATA_W/ADDR_W");
    end
  endgenerate

  logic [DATA_W-1:0] value [NUM_CH];
  logic [NUM_CH-1:0] fresh;
  logic [NUM_CH-1:0] overrun;
  logic [DATA_W-1:0] shadow;
  logic [CH_W-1:0]   shadow_ch;
  logic              shadow_ok;

  logic [CH_W-1:0]   ch;
  logic [1:0]        bidx;
  logic [NUM_CH-1:0] sel;
  logic              in_range;
  logic [23:0]       live;
  logic [23:0]       src;
  logic [1:0]        status;
  logic              b0, b1, b2, b3;
  logic              rd0, rd3;
  logic [7:0]        rdata;
  logic [NUM_CH-1:0] fresh_nxt;
  logic [NUM_CH-1:0] ovr_nxt;

  assign ch   = addr[ADDR_W-1:2];
  assign bidx = addr[1:0];

  assign b0 = (bidx == 2'd0);
  assign b1 = (bidx == 2'd1);
  assign b2 = (bidx == 2'd2);
  assign b3 = (bidx == 2'd3);

  // Channel select and live value/status of the addressed channel
  always_comb begin
    sel    = '0;
    live   = '0;
    status = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == CH_W'(k)) begin
        sel[k] = 1'b1;
        live   = 24'(value[k]);
        status = {overrun[k], fresh[k]};
      end
    end
  end

  assign in_range = |sel;
  assign rd0 = rd_en & in_range & b0;
  assign rd3 = rd_en & in_range & b3;

  assign src = (shadow_ok && shadow_ch == ch)
             ? 24'(shadow) : live;

  // Read byte mux; unmapped channels read as zero
  always_comb begin
    rdata = '0;
    if (in_range) begin
      unique case (1'b1)
        b0: rdata = live[7:0];
        b1: rdata = src[15:8];
        b2: rdata = src[23:16];
        b3: rdata = {6'b0, status};
      endcase
    end
  end

  // Flag next-state: sample events win over read clears
  always_comb begin
    fresh_nxt = fresh;
    ovr_nxt   = overrun;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd0 && sel[k]) fresh_nxt[k] = 1'b0;
      if (rd3 && sel[k]) ovr_nxt[k] = 1'b0;
      if (sample_valid[k]) begin
        if (freeze || fresh[k]) ovr_nxt[k] = 1'b1;
        if (!freeze) fresh_nxt[k] = 1'b1;
      end
    end
  end

  // Per-channel value registers and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CH; k++) value[k] <= '0;
      fresh   <= '0;
      overrun <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (sample_valid[k] && !freeze)
          value[k] <= sample_in[k*DATA_W +: DATA_W];
      end
      fresh   <= fresh_nxt;
      overrun <= ovr_nxt;
    end
  end

  // Shadow snapshot taken on every byte-0 read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow    <= '0;
      shadow_ch <= '0;
      shadow_ok <= 1'b0;
    end else if (rd0) begin
      shadow    <= live[DATA_W-1:0];
      shadow_ch <= ch;
      shadow_ok <= 1'b1;
    end
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) data <= rdata;
    end
  end

endmodule

// File: tb/tb_sensor_reg_bank.sv
// Scoreboard bench for sensor_reg_bank: directed vectors plus
// randomized traffic checked against a behavioural model.
module tb_sensor_reg_bank;

  localparam int NUM_CH = 21;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 8;
  localparam int SW = NUM_CH * DATA_W;
  localparam int MASK = (1 << DATA_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [SW-1:0]     sample_in = '0;
  logic [NUM_CH-1:0] sample_valid = '0;
  logic              freeze = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [7:0]        data;
  logic              rd_valid;

  int checks = 0;
  int errors = 0;

  int unsigned mval [NUM_CH];
  bit          mf [NUM_CH];
  bit          mo [NUM_CH];
  int unsigned msh;
  int          mshch;
  bit          mshok;

  int exp_q[$];
  bit pend;

  sensor_reg_bank #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .freeze(freeze),
    .rd_en(rd_en),
    .addr(addr),
    .data(data),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      mval[k] = 0;
      mf[k] = 0;
      mo[k] = 0;
    end
    msh = 0;
    mshch = 0;
    mshok = 0;
  endtask

  function automatic int model_read(input int a);
    int c, b;
    int unsigned s;
    c = a >> 2;
    b = a & 3;
    if (c >= NUM_CH) return 0;
    s = (mshok && mshch == c) ? msh : mval[c];
    case (b)
      0: return int'(mval[c] & 8'hff);
      1: return int'((s >> 8) & 8'hff);
      2: return int'((s >> 16) & 8'hff);
      default: return (int'(mo[c]) << 1) | int'(mf[c]);
    endcase
  endfunction

  task automatic model_update(input logic [NUM_CH-1:0] sv,
                              input logic [SW-1:0] sin,
                              input bit frz, input bit rd,
                              input int a);
    int c, b;
    bit pf;
    c = a >> 2;
    b = a & 3;
    if (rd && c < NUM_CH && b == 0) begin
      msh = mval[c];
      mshch = c;
      mshok = 1;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      pf = mf[k];
      if (rd && c == k && b == 0) mf[k] = 0;
      if (rd && c == k && b == 3) mo[k] = 0;
      if (sv[k]) begin
        if (frz) begin
          mo[k] = 1;
        end else begin
          if (pf) mo[k] = 1;
          mf[k] = 1;
          mval[k] = int'(sin[k*DATA_W +: DATA_W]) & MASK;
        end
      end
    end
  endtask

  // One clock: drive, predict, then compare just after the edge
  task automatic cyc(input logic [NUM_CH-1:0] sv,
                     input logic [SW-1:0] sin,
                     input bit frz, input bit rd,
                     input int a, input int expv);
    sample_valid = sv;
    sample_in = sin;
    freeze = frz;
    rd_en = rd;
    addr = ADDR_W'(a);
    if (rd) exp_q.push_back(expv < 0 ? model_read(a) : expv);
    model_update(sv, sin, frz, rd, a);
    @(posedge clk);
    #1;
    sample_valid = '0;
    freeze = 1'b0;
    rd_en = 1'b0;
    if (rd) begin
      chk($sformatf("rd_valid@%0h", a), int'(rd_valid), 1);
      if (exp_q.size() == 0) chk("queue_empty", 0, 1);
      else chk($sformatf("data@%0h", a), int'(data), exp_q.pop_front());
    end else begin
      chk("rd_valid_idle", int'(rd_valid), 0);
    end
  endtask

  function automatic logic [SW-1:0] lane(input int c, input int v);
    logic [SW-1:0] r;
    r = '0;
    r[c*DATA_W +: DATA_W] = DATA_W'(v);
    return r;
  endfunction

  task automatic load(input int c, input int v);
    cyc(NUM_CH'(1) << c, lane(c, v), 1'b0, 1'b0, 0, -1);
  endtask

  task automatic rd(input int a, input int e);
    cyc('0, '0, 1'b0, 1'b1, a, e);
  endtask

  initial begin
    logic [NUM_CH-1:0] rsv;
    logic [SW-1:0] rsin;
    model_reset();
    #1;
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(rd_valid), 0);
    @(negedge clk);
    rst = 1'b1;

    // ch0 readback; status read first so fresh is still visible
    load(0, 20'hABCDE);
    rd(3, 8'h01);
    rd(0, 8'hDE);
    rd(1, 8'hBC);
    rd(2, 8'h0A);
    rd(3, 8'h00);

    // shadow coherence across a reload
    load(1, 20'h0A5A5);
    load(2, 20'h12345);
    rd(8, 8'h45);
    load(2, 20'hFFFFF);
    rd(9, 8'h23);
    rd(10, 8'h01);
    rd(5, 8'hA5);
    rd(9, 8'h23);
    rd(8, 8'hFF);
    rd(10, 8'h0F);

    // overrun, and set-wins on simultaneous clear
    load(5, 20'h00011);
    load(5, 20'h00022);
    cyc(NUM_CH'(1) << 5, lane(5, 20'h00033), 1'b0, 1'b1, 23, 8'h03);
    rd(23, 8'h03);
    rd(23, 8'h01);
    rd(20, 8'h33);

    // freeze keeps value, sets overrun, leaves fresh
    load(4, 20'h54321);
    rd(16, 8'h21);
    cyc(NUM_CH'(1) << 4, lane(4, 20'h00077), 1'b1, 1'b0, 0, -1);
    rd(16, 8'h21);
    rd(19, 8'h02);

    // out-of-range channel
    load(20, 20'h00001);
    rd(8'h54, 8'h00);
    rd(8'h57, 8'h00);
    rd(83, 8'h01);

    // reset while read data is valid
    rd(0, 8'hDE);
    rst = 1'b0;
    #1;
    chk("midrst_valid", int'(rd_valid), 0);
    chk("midrst_data", int'(data), 0);
    exp_q.delete();
    model_reset();
    // read issued into an active reset is dropped
    rd_en = 1'b1;
    addr = 8'h03;
    @(posedge clk);
    #1;
    chk("inrst_valid", int'(rd_valid), 0);
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc('0, '0, 1'b0, 1'b0, 0, -1);
    rd(0, 8'h00);
    rd(23, 8'h00);
    rd(9, 8'h00);
    // first edges after release act normally
    cyc(NUM_CH'(1) << 3, lane(3, 20'hC0FFE), 1'b0, 1'b1, 12, 8'h00);
    rd(12, 8'hFE);
    rd(15, 8'h00);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rsv = '0;
      for (int k = 0; k < NUM_CH; k++)
        rsv[k] = ($urandom_range(0, 5) == 0);
      rsin = '0;
      for (int k = 0; k < NUM_CH; k++)
        rsin[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      cyc(rsv, rsin, ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 91)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
